uart_recv: RTL
==============

UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in baud.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 serial_in  input  1  asynchronous UART line; idles high.
REQ-006 data_out  output  8  received byte, LSB first on the wire.
REQ-007 data_out_valid  output  1  data_out holds an unconsumed byte.
REQ-008 data_out_ready  input  1  consumer accepts the byte when high together with data_out_valid.
REQ-009 framing_error  output  1  one-cycle pulse on a bad stop bit (see Configuration).

Function
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-011 BIT_TIME SHALL equal CLOCK_FREQ/BAUD_RATE (integer division); HALF_TIME SHALL equal BIT_TIME/2.
REQ-012 Counter width SHALL be $clog2(BIT_TIME)+1; the counter SHALL never wrap inside a bit.
REQ-013 serial_in SHALL pass through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a synchronized 1->0 transition; the bit-timing counter clears to 0.
REQ-016 In START, at count HALF_TIME: line low -> DATA with counter cleared; line high -> IDLE (glitch rejected, no output, no error).
REQ-017 In DATA, at each count BIT_TIME: sample the line into the shift register MSB end (right shift), clear counter, increment bit index; after the 8th sample -> STOP.
REQ-018 In STOP, at count BIT_TIME: sample the stop bit; then -> IDLE in the next cycle regardless of the value.
REQ-019 Stop sample 1: byte is complete; data_out/data_out_valid update on the cycle after the stop sample.
REQ-020 Output buffer is one entry, independent of the FSM; reception of the next frame proceeds while data_out_valid is high.
REQ-021 data_out_valid SHALL remain high and data_out stable until a cycle with data_out_ready=1; valid deasserts on the following edge.
REQ-022 Byte completes while valid=1 and ready=0: new byte dropped; buffered byte retained unchanged.
REQ-023 Byte completes in the same cycle as a valid&ready handshake: new byte loaded; data_out_valid stays high.
REQ-024 data_out_ready while data_out_valid=0 SHALL have no effect.
REQ-025 Minimum gap between frames is zero: a falling edge in the first IDLE cycle after STOP starts a new frame.

Reset
REQ-026 On reset low, regardless of clk: state=IDLE, counters=0, shift register=0, synchronizer=2'b11, data_out=8'h00, data_out_valid=0, framing_error=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception starts only at the next falling edge.

Configuration
REQ-028 Macro UART_RECV_FRAME_ERR_EN defined: stop sample 0 -> byte discarded, framing_error pulses high for exactly one cycle (the cycle valid would have updated); FSM returns to IDLE.
REQ-029 Macro UART_RECV_FRAME_ERR_EN undefined: framing_error tied 0; the stop bit is not checked; every frame reaching STOP is delivered per REQ-019.

Verification (CLOCK_FREQ=125_000_000, BAUD_RATE=115_200: BIT_TIME=1085, HALF_TIME=542)
REQ-030 Send 0xA5 with ready held 1 -> data_out=0xA5, valid high exactly 1 cycle, about 9.5 bit times + 3 cycles after the start edge.
REQ-031 Send 0x3C then 0xC3 back-to-back, ready=0 until both frames end -> data_out=0x3C stays valid; 0xC3 dropped; after ready pulse valid=0.
REQ-032 Drive a 300-cycle low glitch on an idle line -> no valid and no framing_error; the next 0x55 frame is received correctly.
REQ-033 Frame 0xFF with stop bit 0, macro defined -> framing_error 1-cycle pulse, valid stays 0; macro undefined -> data_out=0xFF, valid=1.
REQ-034 Assert reset during data bit 4 of 0x81, release, send 0x42 -> only 0x42 delivered; all outputs at reset values while reset low.
REQ-035 Ready pulse in the exact cycle a new byte 0x99 completes while 0x11 is buffered -> 0x11 consumed, data_out=0x99, valid stays 1.

Source files
------------

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a one-entry valid/ready output buffer.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   serial_in       asynchronous UART line, idles high
//   data_out[7:0]   received byte (LSB first on the wire)
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer accepts the byte when high together with valid
//   framing_error   one-cycle pulse on a bad stop bit (only when enabled)
//
// Build option: define UART_RECV_FRAME_ERR_EN to check the stop bit; frames
// with a 0 stop bit are then dropped and flagged on framing_error. Without
// it framing_error is tied low and every frame reaching the stop bit is
// delivered.
module uart_recv #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error
);

  localparam int unsigned BIT_TIME  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_TIME = BIT_TIME / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_TIME) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic             rx_c;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             cnt_clr_c;
  logic             shift_en_c;
  logic             stop_samp_c;
  logic             byte_done_c;

  // Two-flop synchronizer plus one flop of history for falling-edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], serial_in};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_c = sync_q[1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    cnt_clr_c   = 1'b0;
    shift_en_c  = 1'b0;
    stop_samp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_c) begin
          state_d   = START;
          cnt_clr_c = 1'b1;
        end
      end
      START: begin
        // Re-check the line mid start bit; a high line means it was a glitch
        if (cnt_q == CNT_W'(HALF_TIME)) begin
          cnt_clr_c = 1'b1;
          state_d   = rx_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(BIT_TIME)) begin
          shift_en_c = 1'b1;
          cnt_clr_c  = 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(BIT_TIME)) begin
          stop_samp_c = 1'b1;
          cnt_clr_c   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (cnt_clr_c || state_q == IDLE) cnt_q <= '0;
      else                              cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == IDLE)  bit_idx_q <= '0;
      else if (shift_en_c)  bit_idx_q <= bit_idx_q + 3'd1;

      if (shift_en_c) shift_q <= {rx_c, shift_q[7:1]};
    end
  end

`ifdef UART_RECV_FRAME_ERR_EN
  assign byte_done_c = stop_samp_c && rx_c;

  // Pulse lands in the cycle a good byte would have appeared on data_out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) framing_error <= 1'b0;
    else        framing_error <= stop_samp_c && !rx_c;
  end
`else
  assign byte_done_c   = stop_samp_c;
  assign framing_error = 1'b0;
`endif

  // One-entry output buffer: a new byte loads only if the slot is empty or
  // being drained this cycle; otherwise it is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
    end else if (byte_done_c && (!data_out_valid || data_out_ready)) begin
      data_out       <= shift_q;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

endmodule
